key_remapper: RTL and testbench

KEY_REMAPPER -- requirements
Module: key_remapper

---
 rtl/keys_pkg.sv | 14 +
 rtl/key_debounce.sv | 43 ++++
 rtl/key_remapper.sv | 138 +++++++++++++
 tb/tb_key_remapper.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keys_pkg.sv
// Shared constants and learn-mode FSM states for the key remapper.
package keys_pkg;

    localparam int DEF_N_KEYS       = 5;
    localparam int DEF_DEBOUNCE_CYC = 20;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REL,
        CAPTURE,
        COMMIT
    } learn_state_t;

endpackage

// File: rtl/key_debounce.sv
// One-bit input conditioner: 2-flop synchroniser followed by a stability counter.
module key_debounce
    import keys_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // The stable level flips on the DEBOUNCE_CYC-th consecutive differing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/key_remapper.sv
// Debounced key inputs routed through a learnable logical-to-physical map,
// with a learn mode that captures one physical key per logical slot.
module key_remapper
    import keys_pkg::*;
#(
    parameter  int N_KEYS       = DEF_N_KEYS,
    parameter  int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    localparam int IDX_W        = ($clog2(N_KEYS) < 1) ? 1 : $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys_raw,
    input  logic              learn_req,
    output logic [N_KEYS-1:0] keys_mapped,
    output logic [N_KEYS-1:0] key_press,
    output logic              learn_busy,
    output logic [IDX_W-1:0]  learn_slot,
    output logic              learn_done
);

    learn_state_t      r_state;
    logic [IDX_W-1:0]  r_map    [N_KEYS];
    logic [IDX_W-1:0]  r_shadow [N_KEYS];
    logic [N_KEYS-1:0] r_used;
    logic [N_KEYS-1:0] r_stablePrev;
    logic [N_KEYS-1:0] r_keysMapped;
    logic [N_KEYS-1:0] r_keyPress;
    logic              r_learnBusy;
    logic [IDX_W-1:0]  r_learnSlot;
    logic              r_learnDone;

    logic [N_KEYS-1:0] w_stable;
    logic [N_KEYS-1:0] w_rise;
    logic [N_KEYS-1:0] w_mappedNext;
    logic [IDX_W-1:0]  w_riseIdx;
    logic              w_oneRise;

    for (genvar g = 0; g < N_KEYS; g++) begin : gen_deb
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_raw    (keys_raw[g]),
            .o_stable (w_stable[g])
        );
    end

    always_comb begin
        w_rise       = w_stable & ~r_stablePrev;
        w_oneRise    = $onehot(w_rise);
        w_riseIdx    = '0;
        w_mappedNext = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (w_rise[i]) w_riseIdx = IDX_W'(i);
            w_mappedNext[i] = w_stable[r_map[i]];
        end
    end

    // Outputs are blanked on the same edge learn_busy rises, so learn_req is part of the gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_used       <= '0;
            r_stablePrev <= '0;
            r_keysMapped <= '0;
            r_keyPress   <= '0;
            r_learnBusy  <= 1'b0;
            r_learnSlot  <= '0;
            r_learnDone  <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                r_map[i]    <= IDX_W'(i);
                r_shadow[i] <= '0;
            end
        end else begin
            r_stablePrev <= w_stable;
            r_learnDone  <= 1'b0;
            if (r_state == IDLE && !learn_req) begin
                r_keysMapped <= w_mappedNext;
                r_keyPress   <= w_mappedNext & ~r_keysMapped;
            end else begin
                r_keysMapped <= '0;
                r_keyPress   <= '0;
            end
            case (r_state)
                IDLE: begin
                    if (learn_req) begin
                        r_state     <= WAIT_REL;
                        r_learnBusy <= 1'b1;
                        r_learnSlot <= '0;
                        r_used      <= '0;
                        for (int i = 0; i < N_KEYS; i++) r_shadow[i] <= '0;
                    end
                end
                WAIT_REL: begin
                    if (learn_req) begin
                        r_state     <= IDLE;
                        r_learnBusy <= 1'b0;
                        r_learnSlot <= '0;
                    end else if (w_stable == '0) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (learn_req) begin
                        r_state     <= IDLE;
                        r_learnBusy <= 1'b0;
                        r_learnSlot <= '0;
                    end else if (w_oneRise && !r_used[w_riseIdx]) begin
                        r_shadow[r_learnSlot] <= w_riseIdx;
                        r_used[w_riseIdx]     <= 1'b1;
                        if (r_learnSlot == IDX_W'(N_KEYS - 1)) begin
                            r_state <= COMMIT;
                        end else begin
                            r_learnSlot <= r_learnSlot + IDX_W'(1);
                            r_state     <= WAIT_REL;
                        end
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < N_KEYS; i++) r_map[i] <= r_shadow[i];
                    r_learnDone <= 1'b1;
                    r_learnBusy <= 1'b0;
                    r_learnSlot <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign keys_mapped = r_keysMapped;
    assign key_press   = r_keyPress;
    assign learn_busy  = r_learnBusy;
    assign learn_slot  = r_learnSlot;
    assign learn_done  = r_learnDone;

endmodule

// File: tb/tb_key_remapper.sv
// Self-checking bench for key_remapper: random debounce traffic against a
// sliding-window reference model, a learn-sequence vector table, and corner cases.
module tb_key_remapper;

    localparam int NK = 5;
    localparam int DB = 20;

    typedef struct {
        logic [4:0] raw;
        int         hold;
        logic [2:0] expSlot;
        logic       expBusy;
        logic [4:0] expMapped;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] keys_raw;
    logic       learn_req;
    logic [4:0] keys_mapped;
    logic [4:0] key_press;
    logic       learn_busy;
    logic [2:0] learn_slot;
    logic       learn_done;

    int assertCount;
    int failCount;
    int doneCount;

    logic       modelOn;
    logic [4:0] mdlStable;
    logic [4:0] expMapped;
    logic [4:0] expPress;
    logic [4:0] mdlNext;
    logic [4:0] rawQ[$];
    int         mdlMap[NK];
    logic       allDiff;

    vec_t learnVec[12];
    int   holdLeft[NK];

    key_remapper #(
        .N_KEYS       (NK),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keys_raw    (keys_raw),
        .learn_req   (learn_req),
        .keys_mapped (keys_mapped),
        .key_press   (key_press),
        .learn_busy  (learn_busy),
        .learn_slot  (learn_slot),
        .learn_done  (learn_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && learn_done) doneCount++;
    end

    // Reference: a key's level flips once the last DB synchronised samples all disagree with it;
    // the synchronised sample seen at an edge is the raw value captured two edges earlier.
    always @(posedge clk) begin
        if (modelOn) begin
            for (int i = 0; i < NK; i++) mdlNext[i] = mdlStable[mdlMap[i]];
            expPress  = mdlNext & ~expMapped;
            expMapped = mdlNext;
            rawQ.push_back(keys_raw);
            void'(rawQ.pop_front());
            for (int k = 0; k < NK; k++) begin
                allDiff = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    if (rawQ[j][k] == mdlStable[k]) allDiff = 1'b0;
                end
                if (allDiff) mdlStable[k] = ~mdlStable[k];
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] raw, input int cycles);
        keys_raw = raw;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulseLearn();
        learn_req = 1'b1;
        @(negedge clk);
        learn_req = 1'b0;
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        keys_raw  = '0;
        learn_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        doneCount = 0;
    endtask

    task automatic learnKey(input logic [4:0] raw, input logic [2:0] expSlot);
        applyStimulus(raw, 25);
        checkOutput("learn_slot after press", 32'(learn_slot), 32'(expSlot));
        applyStimulus('0, 25);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        doneCount   = 0;
        modelOn     = 1'b0;

        learnVec[0]  = '{5'b10000, 25, 3'd1, 1'b1, 5'b00000};
        learnVec[1]  = '{5'b00000, 25, 3'd1, 1'b1, 5'b00000};
        learnVec[2]  = '{5'b01000, 25, 3'd2, 1'b1, 5'b00000};
        learnVec[3]  = '{5'b00000, 25, 3'd2, 1'b1, 5'b00000};
        learnVec[4]  = '{5'b00100, 25, 3'd3, 1'b1, 5'b00000};
        learnVec[5]  = '{5'b00000, 25, 3'd3, 1'b1, 5'b00000};
        learnVec[6]  = '{5'b00010, 25, 3'd4, 1'b1, 5'b00000};
        learnVec[7]  = '{5'b00000, 25, 3'd4, 1'b1, 5'b00000};
        learnVec[8]  = '{5'b00001, 25, 3'd0, 1'b0, 5'b10000};
        learnVec[9]  = '{5'b00000, 25, 3'd0, 1'b0, 5'b00000};
        learnVec[10] = '{5'b10000, 25, 3'd0, 1'b0, 5'b00001};
        learnVec[11] = '{5'b00000, 25, 3'd0, 1'b0, 5'b00000};

        resetDut();
        checkOutput("reset keys_mapped", 32'(keys_mapped), 32'h0);
        checkOutput("reset key_press", 32'(key_press), 32'h0);
        checkOutput("reset learn_busy", 32'(learn_busy), 32'h0);
        checkOutput("reset learn_slot", 32'(learn_slot), 32'h0);
        checkOutput("reset learn_done", 32'(learn_done), 32'h0);

        // Random key traffic with the identity map, compared every cycle.
        rawQ.delete();
        repeat (DB + 2) rawQ.push_back('0);
        mdlStable = '0;
        expMapped = '0;
        expPress  = '0;
        for (int i = 0; i < NK; i++) begin
            mdlMap[i]   = i;
            holdLeft[i] = $urandom_range(3, 45);
        end
        modelOn = 1'b1;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            checkOutput("random keys_mapped", 32'(keys_mapped), 32'(expMapped));
            checkOutput("random key_press", 32'(key_press), 32'(expPress));
            for (int k = 0; k < NK; k++) begin
                holdLeft[k]--;
                if (holdLeft[k] == 0) begin
                    keys_raw[k] = ~keys_raw[k];
                    holdLeft[k] = $urandom_range(3, 45);
                end
            end
        end
        modelOn = 1'b0;

        // Clean press latency on raw key 2.
        resetDut();
        applyStimulus(5'b00100, 22);
        checkOutput("latency mapped before", 32'(keys_mapped), 32'h0);
        checkOutput("latency press before", 32'(key_press), 32'h0);
        applyStimulus(5'b00100, 1);
        checkOutput("latency mapped at 23", 32'(keys_mapped), 32'b00100);
        checkOutput("latency press at 23", 32'(key_press), 32'b00100);
        applyStimulus(5'b00100, 1);
        checkOutput("latency press one cycle", 32'(key_press), 32'h0);
        checkOutput("latency mapped held", 32'(keys_mapped), 32'b00100);
        applyStimulus(5'b00100, 6);
        applyStimulus(5'b00000, 30);

        // Glitching raw key 0 never survives the debouncer.
        resetDut();
        for (int c = 0; c < 200; c++) begin
            keys_raw = ((c / 10) % 2 == 0) ? 5'b00001 : 5'b00000;
            @(negedge clk);
            checkOutput("glitch outputs", {22'h0, keys_mapped, key_press}, 32'h0);
        end

        // Learn a reversed map from the vector table.
        resetDut();
        pulseLearn();
        checkOutput("learn busy after req", 32'(learn_busy), 32'h1);
        for (int v = 0; v < 12; v++) begin
            applyStimulus(learnVec[v].raw, learnVec[v].hold);
            checkOutput($sformatf("vec%0d learn_slot", v), 32'(learn_slot), 32'(learnVec[v].expSlot));
            checkOutput($sformatf("vec%0d learn_busy", v), 32'(learn_busy), 32'(learnVec[v].expBusy));
            checkOutput($sformatf("vec%0d keys_mapped", v), 32'(keys_mapped), 32'(learnVec[v].expMapped));
        end
        checkOutput("learn_done pulses", 32'(doneCount), 32'd1);

        // Simultaneous and already-used presses in slot 1 are ignored.
        doneCount = 0;
        pulseLearn();
        learnKey(5'b10000, 3'd1);
        learnKey(5'b01010, 3'd1);
        learnKey(5'b10000, 3'd1);
        learnKey(5'b00001, 3'd2);
        learnKey(5'b00010, 3'd3);
        learnKey(5'b00100, 3'd4);
        applyStimulus(5'b01000, 25);
        checkOutput("ignore commit busy", 32'(learn_busy), 32'h0);
        applyStimulus(5'b00000, 25);
        checkOutput("ignore done count", 32'(doneCount), 32'd1);
        applyStimulus(5'b00001, 25);
        checkOutput("ignore map raw0", 32'(keys_mapped), 32'b00010);
        applyStimulus(5'b00000, 25);
        applyStimulus(5'b01000, 25);
        checkOutput("ignore map raw3", 32'(keys_mapped), 32'b10000);
        applyStimulus(5'b00000, 25);

        // Reset mid-learn with key 0 held restores identity and discards the partial map.
        doneCount = 0;
        pulseLearn();
        learnKey(5'b10000, 3'd1);
        learnKey(5'b01000, 3'd2);
        applyStimulus(5'b00001, 5);
        checkOutput("pre-reset busy", 32'(learn_busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset outputs", {22'h0, keys_mapped, key_press}, 32'h0);
        checkOutput("async reset busy/slot/done", {28'h0, learn_busy, learn_slot}, 32'h0);
        checkOutput("async reset done", 32'(learn_done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (22) @(negedge clk);
        checkOutput("post-reset press before 23", 32'(key_press), 32'h0);
        @(negedge clk);
        checkOutput("post-reset press at 23", 32'(key_press), 32'b00001);
        checkOutput("post-reset identity map", 32'(keys_mapped), 32'b00001);
        @(negedge clk);
        checkOutput("post-reset press one cycle", 32'(key_press), 32'h0);
        checkOutput("post-reset no done", 32'(doneCount), 32'd0);

        // Abort at slot 3 leaves the map unchanged.
        resetDut();
        pulseLearn();
        learnKey(5'b10000, 3'd1);
        learnKey(5'b01000, 3'd2);
        learnKey(5'b00100, 3'd3);
        pulseLearn();
        checkOutput("abort busy", 32'(learn_busy), 32'h0);
        checkOutput("abort slot", 32'(learn_slot), 32'h0);
        applyStimulus(5'b10000, 25);
        checkOutput("abort identity map", 32'(keys_mapped), 32'b10000);
        checkOutput("abort no done", 32'(doneCount), 32'd0);
        applyStimulus(5'b00000, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
